// File: rtl/ctrl_pkg.sv
// Shared types and constants for the hardwired control unit:
// state encoding, opcodes, ALU operation codes and instruction field positions.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_t;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_MUL = 4'd4;
  localparam logic [3:0] ALU_DIV = 4'd5;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

endpackage

// File: rtl/datapath_control_unit_if.sv
// Control-unit <-> datapath bundle: start/ir in, status and every datapath strobe out.
interface datapath_control_unit_if;
  logic        start;
  logic [31:0] ir;
  logic        run;
  logic        done;
  logic        illegal;
  logic [15:0] instr_count;
  logic        PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic        Zlowout, Zhighout, HIin, LOin;
  logic        Gra, Grb, Grc, Rin, Rout;
  logic [3:0]  alu_op;

  modport master (
    input  start, ir,
    output run, done, illegal, instr_count,
    output PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
    output Zlowout, Zhighout, HIin, LOin,
    output Gra, Grb, Grc, Rin, Rout, alu_op
  );

  modport slave (
    output start, ir,
    input  run, done, illegal, instr_count,
    input  PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
    input  Zlowout, Zhighout, HIin, LOin,
    input  Gra, Grb, Grc, Rin, Rout, alu_op
  );
endinterface

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: instruction class flags plus the ALU operation code.
module opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       is_alu,
  output logic       is_muldiv,
  output logic       is_halt,
  output logic       is_illegal,
  output logic [3:0] alu_op
);

  always_comb begin
    is_alu     = 1'b0;
    is_muldiv  = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    alu_op     = ALU_ADD;
    case (opcode)
      OPC_ADD:  begin is_alu = 1'b1;    alu_op = ALU_ADD; end
      OPC_SUB:  begin is_alu = 1'b1;    alu_op = ALU_SUB; end
      OPC_AND:  begin is_alu = 1'b1;    alu_op = ALU_AND; end
      OPC_OR:   begin is_alu = 1'b1;    alu_op = ALU_OR;  end
      OPC_MUL:  begin is_muldiv = 1'b1; alu_op = ALU_MUL; end
      OPC_DIV:  begin is_muldiv = 1'b1; alu_op = ALU_DIV; end
      OPC_HALT: is_halt = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_control_unit.sv
// Hardwired Moore control unit: fetch (T0-T2), decode (T3) and execute of
// ALU and MUL/DIV register instructions, with halt and illegal-opcode trapping.
module datapath_control_unit
  import ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    clr,
  datapath_control_unit_if.master bus
);

  state_t      state_reg, state_next;
  logic        illegal_reg;
  logic [15:0] count_reg;

  logic        is_alu, is_muldiv, is_halt, is_illegal;
  logic [3:0]  dec_op;
  logic        done_int;

  opcode_decoder u_dec (
    .opcode     (bus.ir[OP_MSB:OP_LSB]),
    .is_alu     (is_alu),
    .is_muldiv  (is_muldiv),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .alu_op     (dec_op)
  );

  assign done_int = ((state_reg == S_T5) && !is_muldiv) || (state_reg == S_T6);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg   <= S_IDLE;
      illegal_reg <= 1'b0;
      count_reg   <= 16'd0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == S_T3) && is_illegal)
        illegal_reg <= 1'b1;
      if (done_int)
        count_reg <= count_reg + 16'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.start) state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1:    state_next = S_T2;
      S_T2:    state_next = S_T3;
      S_T3:    state_next = (is_halt || is_illegal) ? S_HALT : S_T4;
      S_T4:    state_next = S_T5;
      S_T5:    state_next = is_muldiv ? S_T6 : S_T0;
      S_T6:    state_next = S_T0;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes depend only on the state register and the held ir, so they are stable all cycle.
  always_comb begin
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Zin      = 1'b0;
    bus.PCin     = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.alu_op   = 4'd0;
    case (state_reg)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        if (is_alu || is_muldiv) begin
          bus.Gra  = is_muldiv;
          bus.Grb  = is_alu;
          bus.Rout = 1'b1;
          bus.Yin  = 1'b1;
        end
      end
      S_T4: begin
        bus.Grb    = is_muldiv;
        bus.Grc    = !is_muldiv;
        bus.Rout   = 1'b1;
        bus.Zin    = 1'b1;
        bus.alu_op = dec_op;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        bus.LOin    = is_muldiv;
        bus.Gra     = !is_muldiv;
        bus.Rin     = !is_muldiv;
      end
      S_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.run         = (state_reg != S_IDLE) && (state_reg != S_HALT);
  assign bus.done        = done_int;
  assign bus.illegal     = illegal_reg;
  assign bus.instr_count = count_reg;

endmodule

// File: doc/datapath_control_unit.md
# datapath_control_unit

Hardwired control unit that sequences the 32-bit datapath through instruction fetch and execution of register-format ALU, MUL and DIV instructions. It drives every per-cycle control strobe the datapath needs: PC/MAR/MDR/IR loads, Y/Z/HI/LO loads, bus-out selects and the ALU operation. General-register selection is emitted as Gra/Grb/Grc plus Rin/Rout for the select-and-encode logic. It sits beside the datapath and replaces hand-driven control sequences.

## Interface
- No parameters.
- clk  in  1  system clock, all state changes on rising edge
- clr  in  1  synchronous, active-high reset
- start  in  1  begin execution; honoured only in IDLE
- ir  in  32  instruction register contents from datapath
- run  out  1  high in any state other than IDLE and HALT
- done  out  1  one-cycle pulse in the last execute cycle of each instruction
- illegal  out  1  sticky; set on entering HALT via an undefined opcode
- instr_count  out  16  completed-instruction counter, wraps 0xFFFF→0
- PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes
- Zlowout, Zhighout, HIin, LOin  out  1 each  Z/HI/LO strobes
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-field select and direction
- alu_op  out  4  ALU operation, valid only in T4, 0 elsewhere

## Operation
- Opcode field: ir[31:27].
- Register fields: ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
- Opcodes and operations:
  - ADD 00011, SUB 00100, AND 00101, OR 00110: ra ← rb op rc.
  - MUL 01111, DIV 10000: {HI,LO} ← ra op rb.
  - HALT 11011.
  - Any other opcode is illegal.
- States: IDLE, T0–T6, HALT. Moore outputs; every strobe not listed for a state is 0.
  - IDLE: all outputs 0. start → T0.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3: ir valid, decoded here.
    - ALU ops: Grb, Rout, Yin.
    - MUL/DIV: Gra, Rout, Yin.
    - HALT opcode: no strobes; next state HALT.
    - Illegal opcode: no strobes; next state HALT, illegal set.
  - T4:
    - ALU ops: Grc, Rout, Zin, alu_op.
    - MUL/DIV: Grb, Rout, Zin, alu_op.
  - T5:
    - ALU ops: Zlowout, Gra, Rin, done; next T0.
    - MUL/DIV: Zlowout, LOin; next T6.
  - T6 (MUL/DIV only): Zhighout, HIin, done; next T0.
  - HALT: all strobes 0, run 0. Exit only via clr; start ignored.
- Execution is continuous: after done, the next state is T0 with no return to IDLE.
- alu_op encoding: ADD 0, SUB 1, AND 2, OR 3, MUL 4, DIV 5.
- instr_count increments on the clock edge that leaves a done cycle. HALT and illegal instructions are not counted.
- start asserted outside IDLE has no effect.

## Timing
- Reset: clr high at a rising edge forces the following values, regardless of state (clr wins over start):
  - state IDLE
  - all strobes 0, alu_op 0
  - run, done, illegal 0
  - instr_count 0
- Reset mid-instruction abandons the instruction; no strobe persists past the reset edge.
- Latency:
  - start sampled in IDLE → T0 strobes in the next cycle.
  - Fetch: 3 cycles.
  - ALU instruction: 6 cycles (T0–T5).
  - MUL/DIV: 7 cycles (T0–T6).
- Outputs are decoded only from the state register and the ir fields. They change only after a rising edge and are glitch-free for a full cycle.
- ir must be stable from T3 through the end of the instruction; the datapath guarantees this because IRin is asserted only in T2.

## Structure
- Package ctrl_pkg holds:
  - state enum (IDLE, T0–T6, HALT)
  - opcode constants
  - alu_op constants
  - field-position constants for op/ra/rb/rc
- One sub-module, opcode_decoder: combinational ir[31:27] → {is_alu, is_muldiv, is_halt, is_illegal, alu_op}.
- The top level holds the state register, illegal flag and instr_count.

## Test plan
- Reset idle: clr 2 cycles, start=0 for 5 cycles → every output 0, run=0, instr_count=0.
- AND fetch/execute: start pulse, ir=0x28918000 (and R1,R2,R3) from T3:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=2.
  - T5: Zlowout, Gra, Rin, done.
  - T0 again 7 cycles after start; instr_count=1.
- MUL: ir=0x7A280000 (mul R4,R5):
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, Zin, alu_op=4.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin, done.
- HALT: ir=0xD8000000 → HALT after T3, run=0, illegal=0, start pulses ignored; clr → IDLE.
- Illegal: ir=0xF8000000 → HALT, illegal=1, instr_count unchanged.
- Reset mid-MUL: clr during T4 → next cycle all outputs 0, state IDLE, instr_count=0; a following start performs a clean T0.
